systolic_feeder: RTL
====================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter: data_size, 32, signed operand width.
REQ-002 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: wr_en  in  1  operand-store write strobe.
REQ-005 SHALL have port: wr_sel  in  1  0 = matrix A store, 1 = matrix B store.
REQ-006 SHALL have port: wr_addr  in  4  element index, row*4+col.
REQ-007 SHALL have port: wr_data  in  data_size  signed element value.
REQ-008 SHALL have port: start  in  1  begin one 4x4 multiply pass.
REQ-009 SHALL have port: busy  out  1  high from accepted start until done.
REQ-010 SHALL have port: done  out  1  one-cycle pulse; array c1..c16 hold A*B.
REQ-011 SHALL have port: arr_clr  out  1  accumulator-clear pulse, ORed into array reset.
REQ-012 SHALL have port: a1..a4  out  data_size each  registered skewed row operands to the array.
REQ-013 SHALL have port: b1..b4  out  data_size each  registered skewed column operands to the array.

Function
REQ-014 SHALL hold two 16-entry signed stores, A and B, written on wr_en when busy=0.
REQ-015 SHALL ignore wr_en while busy=1, keeping stores stable during a pass.
REQ-016 SHALL implement states IDLE, CLEAR, FEED, DONE.
REQ-017 SHALL, in IDLE, move to CLEAR on start; IDLE holds busy=0.
REQ-018 SHALL, in CLEAR, last one cycle: arr_clr=1, a/b outputs zero, busy=1.
REQ-019 SHALL, in FEED, run a 4-bit cycle counter t over 0..9 (10 cycles); move to DONE after t=9.
REQ-020 SHALL, during FEED cycle t, drive a(r+1)=A[r][t-r] when 0<=t-r<=3, else 0 (r=0..3).
REQ-021 SHALL, during FEED cycle t, drive b(c+1)=B[t-c][c] when 0<=t-c<=3, else 0 (c=0..3).
REQ-022 SHALL drive all a/b outputs to zero for t=7..9 (drain) and in every non-FEED state, so array accumulators hold.
REQ-023 SHALL, in DONE, last one cycle: done=1, busy=1; then return to IDLE.
REQ-024 SHALL ignore start while busy=1; the earliest re-start is accepted in the cycle after DONE.
REQ-025 SHALL apply a write on the same edge that start is accepted in IDLE, so the pass uses the new value.
REQ-026 SHALL have a total latency of 12 cycles from the accepting edge to done: 1 CLEAR + 10 FEED + 1 DONE.
REQ-027 SHALL pass operands unmodified, without saturation or rounding; width handling belongs to the array.

Reset
REQ-028 SHALL, on reset, force IDLE, t=0, busy=0, done=0, arr_clr=0, and a1..a4, b1..b4 to 0.
REQ-029 SHALL clear both stores to zero on reset.
REQ-030 SHALL abandon a pass on reset mid-FEED, with no done pulse; array accumulators are cleared by the shared reset.

Configuration
REQ-031 SHALL, when SYSTOLIC_FEEDER_BT_EN is defined, interpret wr_addr for the B store as col*4+row (transposed load); A is unaffected.
REQ-032 SHALL, when SYSTOLIC_FEEDER_BT_EN is undefined, interpret wr_addr as row*4+col for both stores.

Verification
REQ-033 SHALL verify: A = identity, B[r][c]=r*4+c+1, start -> done at edge 12; array c(r*4+c+1) = r*4+c+1.
REQ-034 SHALL verify: A = B = all 2, start -> every c = 16; cycle t=3 a/b outputs all 2, cycle t=0 only a1=b1=2.
REQ-035 SHALL verify: A[r][c] = -(r+1), B = all 3 -> row r results all = -12*(r+1); signed path exercised.
REQ-036 SHALL verify: start and wr_en pulsed at FEED t=4 -> no restart, store unchanged, single done at edge 12.
REQ-037 SHALL verify: reset asserted at FEED t=5 -> next cycle busy=0, outputs 0, no done; a new start completes normally.
REQ-038 SHALL verify: with SYSTOLIC_FEEDER_BT_EN defined, write B via addr 1 = 7 -> B[1][0]=7 and b1 = 7 at FEED t=1.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand stores plus skew sequencer feeding a 4x4 output-stationary systolic array.
// Latency: 12 cycles from accepted start to done (1 clear + 10 feed + 1 done).
// Backpressure: start and writes are ignored while busy; SYSTOLIC_FEEDER_BT_EN makes B loads transposed.
module systolic_feeder #(
    parameter int data_size = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic                        wr_sel,
    input  logic [3:0]                  wr_addr,
    input  logic signed [data_size-1:0] wr_data,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        arr_clr,
    output logic signed [data_size-1:0] a1,
    output logic signed [data_size-1:0] a2,
    output logic signed [data_size-1:0] a3,
    output logic signed [data_size-1:0] a4,
    output logic signed [data_size-1:0] b1,
    output logic signed [data_size-1:0] b2,
    output logic signed [data_size-1:0] b3,
    output logic signed [data_size-1:0] b4
);
    typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

    state_t                      state;
    logic [3:0]                  t;
    logic [3:0]                  tn;
    logic [3:0]                  b_idx;
    logic signed [data_size-1:0] mem_a [16];
    logic signed [data_size-1:0] mem_b [16];
    logic signed [data_size-1:0] a_q   [4];
    logic signed [data_size-1:0] b_q   [4];
    logic signed [data_size-1:0] a_nxt [4];
    logic signed [data_size-1:0] b_nxt [4];

`ifdef SYSTOLIC_FEEDER_BT_EN
    assign b_idx = {wr_addr[1:0], wr_addr[3:2]};
`else
    assign b_idx = wr_addr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else if (wr_en && !busy) begin
            if (wr_sel)
                mem_b[b_idx] <= wr_data;
            else
                mem_a[wr_addr] <= wr_data;
        end
    end

    // Operands for the feed cycle that follows this edge; the diagonal window
    // closes by t=6, so the drain cycles fall out as zeros automatically.
    always_comb begin
        tn = (state == FEED) ? t + 4'd1 : 4'd0;
        for (int i = 0; i < 4; i++) begin
            automatic logic [3:0] k = tn - 4'(i);
            a_nxt[i] = '0;
            b_nxt[i] = '0;
            if (tn >= 4'(i) && k <= 4'd3) begin
                a_nxt[i] = mem_a[{2'(i), k[1:0]}];
                b_nxt[i] = mem_b[{k[1:0], 2'(i)}];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            t       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            arr_clr <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            arr_clr <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        arr_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= FEED;
                    t     <= '0;
                    for (int i = 0; i < 4; i++) begin
                        a_q[i] <= a_nxt[i];
                        b_q[i] <= b_nxt[i];
                    end
                end
                FEED: begin
                    if (t == 4'd9) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        t <= t + 4'd1;
                        for (int i = 0; i < 4; i++) begin
                            a_q[i] <= a_nxt[i];
                            b_q[i] <= b_nxt[i];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a1 = a_q[0];
    assign a2 = a_q[1];
    assign a3 = a_q[2];
    assign a4 = a_q[3];
    assign b1 = b_q[0];
    assign b2 = b_q[1];
    assign b3 = b_q[2];
    assign b4 = b_q[3];
endmodule
